// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard controller.
package hazard_detection_unit_pkg;

    // Default register identifier width; the top module exposes it as a parameter.
    localparam int NB_REG_DFLT = 5;

    // $zero never carries a real dependency.
    localparam logic [NB_REG_DFLT-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hdu_state_t;

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: bubbles for hazards forwarding cannot cover,
// IF/ID squash on taken control flow, debug halt/drain sequencing and
// stall/flush statistics.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_RUN    | normal issue; hazard stalls and branch squashes active
//  ST_DRAIN  | front end frozen, bubbles pushed until EX/M/WB are empty
//  ST_HALTED | pipeline drained and frozen; o_halted asserted
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int NB_REG       = NB_REG_DFLT,
    parameter int NB_CNT       = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NB_REG-1:0] i_rs_from_ID,
    input  logic [NB_REG-1:0] i_rt_from_ID,
    input  logic              i_uses_rs,
    input  logic              i_uses_rt,
    input  logic              i_branch_in_ID,
    input  logic              i_jump_taken,
    input  logic [NB_REG-1:0] i_write_reg_from_EX,
    input  logic              i_RegWrite_from_EX,
    input  logic              i_MemRead_from_EX,
    input  logic [NB_REG-1:0] i_write_reg_from_M,
    input  logic              i_MemRead_from_M,
    input  logic              i_halt,
    input  logic              i_cnt_clear,
    output logic              o_pc_write,
    output logic              o_IF_ID_write,
    output logic              o_IF_ID_flush,
    output logic              o_ID_EX_flush,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_stall_cnt,
    output logic [NB_CNT-1:0] o_flush_cnt
);

    localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);
    localparam logic [NB_REG-1:0] ZERO_REG = NB_REG'(REG_ZERO);

    hdu_state_t state, state_next;
    logic [NB_DRAIN-1:0] drain_cnt, drain_cnt_next;
    logic halted_q;

    logic rs_live, rt_live;
    logic rs_hit_ex, rt_hit_ex, rs_hit_m, rt_hit_m;
    logic load_use, br_ex, br_ld_m, stall;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic stall_inc;

    // Source operands that actually carry a dependency (never $zero).
    always_comb begin
        rs_live   = i_uses_rs && (i_rs_from_ID != ZERO_REG);
        rt_live   = i_uses_rt && (i_rt_from_ID != ZERO_REG);
        rs_hit_ex = rs_live && (i_rs_from_ID == i_write_reg_from_EX);
        rt_hit_ex = rt_live && (i_rt_from_ID == i_write_reg_from_EX);
        rs_hit_m  = rs_live && (i_rs_from_ID == i_write_reg_from_M);
        rt_hit_m  = rt_live && (i_rt_from_ID == i_write_reg_from_M);
    end

    // Hazards that forwarding into EX cannot resolve. Branches compare in ID,
    // so an ALU result still in EX or a load result still in M is too late.
    always_comb begin
        load_use = i_MemRead_from_EX && (rs_hit_ex || rt_hit_ex);
        br_ex    = i_branch_in_ID && i_RegWrite_from_EX && (rs_hit_ex || rt_hit_ex);
        br_ld_m  = i_branch_in_ID && i_MemRead_from_M && (rs_hit_m || rt_hit_m);
        stall    = load_use || br_ex || br_ld_m;
    end

    // Next-state, drain timer and pipeline controls.
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;

        case (state)
            ST_RUN: begin
                if (stall) begin
                    // Operands are not valid yet, so a jump decision this cycle is ignored.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (i_jump_taken) begin
                    if_id_flush = 1'b1;
                end
                if (i_halt) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (drain_cnt == '0) begin
                    state_next = ST_HALTED;
                end else begin
                    drain_cnt_next = drain_cnt - 1'b1;
                end
            end
            ST_HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                if (!i_halt) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // State register, drain down-counter and registered halted flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted_q  <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            halted_q  <= (state_next == ST_HALTED);
        end
    end

    assign stall_inc = (state == ST_RUN) && stall;

    sat_counter #(.WIDTH(NB_CNT)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (stall_inc),
        .clear (i_cnt_clear),
        .cnt   (o_stall_cnt)
    );

    sat_counter #(.WIDTH(NB_CNT)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (if_id_flush),
        .clear (i_cnt_clear),
        .cnt   (o_flush_cnt)
    );

    assign o_pc_write    = pc_write;
    assign o_IF_ID_write = if_id_write;
    assign o_IF_ID_flush = if_id_flush;
    assign o_ID_EX_flush = id_ex_flush;
    assign o_halted      = halted_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: vector table plus
// multi-cycle sequences, with a narrow-counter second instance for saturation.
module tb_hazard_detection_unit;

    localparam int NB_REG   = 5;
    localparam int NB_CNT   = 16;
    localparam int NB_CNT_S = 4;

    // Expected output bundle: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, halted}
    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_JMP   = 5'b11100;
    localparam logic [4:0] O_DRAIN = 5'b00010;
    localparam logic [4:0] O_HALT  = 5'b00011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NB_REG-1:0] rs, rt, wex, wm;
    logic              urs, urt, br, jt, rwex, mrex, mrm, hlt, clr;

    logic              pcw, ifidw, ifidf, idexf, halted;
    logic [NB_CNT-1:0] st_cnt, fl_cnt;
    logic              pcw_s, ifidw_s, ifidf_s, idexf_s, halted_s;
    logic [NB_CNT_S-1:0] st_cnt_s, fl_cnt_s;

    hazard_detection_unit #(.NB_REG(NB_REG), .NB_CNT(NB_CNT), .DRAIN_CYCLES(3)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs_from_ID(rs), .i_rt_from_ID(rt), .i_uses_rs(urs), .i_uses_rt(urt),
        .i_branch_in_ID(br), .i_jump_taken(jt),
        .i_write_reg_from_EX(wex), .i_RegWrite_from_EX(rwex), .i_MemRead_from_EX(mrex),
        .i_write_reg_from_M(wm), .i_MemRead_from_M(mrm),
        .i_halt(hlt), .i_cnt_clear(clr),
        .o_pc_write(pcw), .o_IF_ID_write(ifidw), .o_IF_ID_flush(ifidf), .o_ID_EX_flush(idexf),
        .o_halted(halted), .o_stall_cnt(st_cnt), .o_flush_cnt(fl_cnt)
    );

    hazard_detection_unit #(.NB_REG(NB_REG), .NB_CNT(NB_CNT_S), .DRAIN_CYCLES(3)) u_dut_s (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs_from_ID(rs), .i_rt_from_ID(rt), .i_uses_rs(urs), .i_uses_rt(urt),
        .i_branch_in_ID(br), .i_jump_taken(jt),
        .i_write_reg_from_EX(wex), .i_RegWrite_from_EX(rwex), .i_MemRead_from_EX(mrex),
        .i_write_reg_from_M(wm), .i_MemRead_from_M(mrm),
        .i_halt(hlt), .i_cnt_clear(clr),
        .o_pc_write(pcw_s), .o_IF_ID_write(ifidw_s), .o_IF_ID_flush(ifidf_s), .o_ID_EX_flush(idexf_s),
        .o_halted(halted_s), .o_stall_cnt(st_cnt_s), .o_flush_cnt(fl_cnt_s)
    );

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, br, jt;
        logic [4:0] wex;
        logic       rwex, mrex;
        logic [4:0] wm;
        logic       mrm, hlt, clr;
        logic [4:0] e;
        logic       run;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[12];

    int n_chk  = 0;
    int n_pass = 0;
    int m_st   = 0;
    int m_fl   = 0;
    int m_st_s = 0;
    int m_fl_s = 0;

    function automatic vec_t mk(input int a_rs, a_rt, a_urs, a_urt, a_br, a_jt,
                                input int a_wex, a_rwex, a_mrex, a_wm, a_mrm, a_hlt, a_clr,
                                input logic [4:0] a_e, input int a_run);
        vec_t v;
        v.rs = 5'(a_rs);   v.rt = 5'(a_rt);
        v.urs = 1'(a_urs); v.urt = 1'(a_urt);
        v.br = 1'(a_br);   v.jt = 1'(a_jt);
        v.wex = 5'(a_wex); v.rwex = 1'(a_rwex); v.mrex = 1'(a_mrex);
        v.wm = 5'(a_wm);   v.mrm = 1'(a_mrm);
        v.hlt = 1'(a_hlt); v.clr = 1'(a_clr);
        v.e = a_e;         v.run = 1'(a_run);
        return v;
    endfunction

    function automatic int nxt(input int c, input logic inc, input logic clear, input int mx);
        if (clear) return 0;
        if (inc && c < mx) return c + 1;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t t);
        rs = t.rs; rt = t.rt; urs = t.urs; urt = t.urt; br = t.br; jt = t.jt;
        wex = t.wex; rwex = t.rwex; mrex = t.mrex; wm = t.wm; mrm = t.mrm;
        hlt = t.hlt; clr = t.clr;
    endtask

    // One clock cycle: drive after the edge, check at the falling edge.
    task automatic step(input vec_t t);
        vec_t x;
        @(posedge clk);
        #1;
        drive(t);
        sb.push_back(t);
        @(negedge clk);
        x = sb.pop_front();
        chk("outs", 32'({pcw, ifidw, ifidf, idexf, halted}), 32'(x.e));
        chk("outs_s", 32'({pcw_s, ifidw_s, ifidf_s, idexf_s, halted_s}), 32'(x.e));
        chk("stall_cnt", 32'(st_cnt), m_st);
        chk("flush_cnt", 32'(fl_cnt), m_fl);
        chk("stall_cnt_s", 32'(st_cnt_s), m_st_s);
        chk("flush_cnt_s", 32'(fl_cnt_s), m_fl_s);
        m_st   = nxt(m_st,   x.run && x.e[1], x.clr, 65535);
        m_fl   = nxt(m_fl,   x.e[2],          x.clr, 65535);
        m_st_s = nxt(m_st_s, x.run && x.e[1], x.clr, 15);
        m_fl_s = nxt(m_fl_s, x.e[2],          x.clr, 15);
    endtask

    vec_t idle;

    initial begin
        idle = mk(0,0,0,0,0,0, 0,0,0, 0,0,0,0, O_RUN,1);
        rst_n = 1'b0;
        drive(idle);

        // args: rs rt urs urt br jt | wex rwex mrex | wm mrm hlt clr | expected run
        tbl[0]  = mk(0,0,0,0,0,0,  0,0,0,  0,0,0,0, O_RUN,1);
        tbl[1]  = mk(5,2,1,1,0,0,  5,1,1,  0,0,0,0, O_STALL,1);
        tbl[2]  = mk(1,6,1,0,0,0,  6,1,1,  0,0,0,0, O_RUN,1);
        tbl[3]  = mk(1,6,1,1,0,0,  6,1,1,  0,0,0,0, O_STALL,1);
        tbl[4]  = mk(0,0,1,1,0,0,  0,1,1,  0,0,0,0, O_RUN,1);
        tbl[5]  = mk(4,7,1,1,1,1,  7,1,0,  0,0,0,0, O_STALL,1);
        tbl[6]  = mk(4,7,1,1,0,0,  7,1,0,  0,0,0,0, O_RUN,1);
        tbl[7]  = mk(0,0,0,0,1,1,  0,0,0,  0,0,0,0, O_JMP,1);
        tbl[8]  = mk(3,9,1,1,1,0,  0,0,0,  3,1,0,0, O_STALL,1);
        tbl[9]  = mk(3,9,1,1,0,0,  0,0,0,  3,1,0,0, O_RUN,1);
        tbl[10] = mk(4,8,1,1,1,1,  9,1,0, 10,0,0,0, O_JMP,1);
        tbl[11] = mk(0,9,1,0,1,0,  0,0,0,  0,1,0,0, O_RUN,1);

        #2;
        chk("reset_outs", 32'({pcw, ifidw, ifidf, idexf, halted}), 32'(O_RUN));
        chk("reset_stall_cnt", 32'(st_cnt), 0);
        chk("reset_flush_cnt", 32'(fl_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) step(tbl[i]);

        // lw $5 in EX, add uses $5: one bubble, then the load is in M
        step(mk(5,0,1,0,0,0,  5,1,1,  0,0,0,0, O_STALL,1));
        step(mk(5,0,1,0,0,0,  0,0,0,  5,1,0,0, O_RUN,1));

        // lw $3 in EX, beq on $3: two bubbles
        step(mk(3,0,1,1,1,0,  3,1,1,  0,0,0,0, O_STALL,1));
        step(mk(3,0,1,1,1,0,  0,0,0,  3,1,0,0, O_STALL,1));
        step(mk(3,0,1,1,1,0,  0,0,0,  0,0,0,0, O_RUN,1));

        // add $7 in EX, beq on $7 taken: stall first, squash next cycle
        step(mk(0,7,0,1,1,1,  7,1,0,  0,0,0,0, O_STALL,1));
        step(mk(0,7,0,1,1,1,  0,0,0,  7,0,0,0, O_JMP,1));
        step(idle);

        // One-cycle halt pulse, hazards presented during drain are ignored
        step(mk(0,0,0,0,0,0,  0,0,0,  0,0,1,0, O_RUN,1));
        step(mk(5,0,1,0,0,0,  5,1,1,  0,0,0,0, O_DRAIN,0));
        step(mk(5,0,1,0,1,1,  5,1,1,  0,0,0,0, O_DRAIN,0));
        step(mk(0,0,0,0,0,0,  0,0,0,  0,0,0,0, O_DRAIN,0));
        step(mk(0,0,0,0,0,0,  0,0,0,  0,0,0,0, O_HALT,0));
        step(idle);

        // Held halt: stays halted until released, halt wins over a stall
        step(mk(5,0,1,0,0,0,  5,1,1,  0,0,1,0, O_STALL,1));
        for (int i = 0; i < 3; i++) step(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,0, O_DRAIN,0));
        for (int i = 0; i < 3; i++) step(mk(0,0,0,0,0,0, 0,0,0, 0,0,1,0, O_HALT,0));
        step(mk(0,0,0,0,0,0,  0,0,0,  0,0,0,0, O_HALT,0));
        step(idle);

        // Saturation of the narrow counters, then clear beats increment
        for (int i = 0; i < 20; i++) step(mk(2,0,1,0,0,0, 2,1,1, 0,0,0,0, O_STALL,1));
        for (int i = 0; i < 17; i++) step(mk(0,0,0,0,1,1, 0,0,0, 0,0,0,0, O_JMP,1));
        step(mk(2,0,1,0,0,0,  2,1,1,  0,0,0,1, O_STALL,1));
        step(mk(2,0,1,0,0,0,  2,1,1,  0,0,0,0, O_STALL,1));
        step(mk(0,0,0,0,1,1,  0,0,0,  0,0,0,0, O_JMP,1));
        step(idle);

        // Reset asserted in the middle of a drain
        step(mk(0,0,0,0,0,0,  0,0,0,  0,0,1,0, O_RUN,1));
        step(mk(0,0,0,0,0,0,  0,0,0,  0,0,1,0, O_DRAIN,0));
        #1;
        drive(idle);
        rst_n = 1'b0;
        #1;
        chk("rst_drain_outs", 32'({pcw, ifidw, ifidf, idexf, halted}), 32'(O_RUN));
        chk("rst_drain_stall_cnt", 32'(st_cnt), 0);
        chk("rst_drain_flush_cnt", 32'(fl_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_st = 0; m_fl = 0; m_st_s = 0; m_fl_s = 0;
        step(idle);
        step(mk(5,0,1,0,0,0,  5,1,1,  0,0,0,0, O_STALL,1));
        step(idle);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
